// File: rtl/collision_monitor.sv
// Collision monitor: per-frame cube/obstacle overlap detection, cleared-line scoring and play/hit/over sequencing.
// Optional SCORE_BCD_EN: score held as two packed BCD digits (SCORE_W must be 8), saturating at 8'h99.
module collision_monitor #(
    parameter int N_LINES     = 5,
    parameter int SCORE_W     = 8,
    parameter int HIT_THRESH  = 4,
    parameter int HOLD_FRAMES = 60,
    localparam int HL_W       = $clog2(N_LINES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic               frame_tick,
    input  logic               cube_px,
    input  logic [N_LINES-1:0] obstacle_px,
    input  logic [N_LINES-1:0] col_px,
    input  logic               border_px,
    input  logic               start,
    input  logic               clear,
    output logic               run,
    output logic               hit,
    output logic [HL_W-1:0]    hit_line,
    output logic               game_over,
    output logic [SCORE_W-1:0] score
);

    localparam int CNT_W  = $clog2(HIT_THRESH + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, PLAY, HIT_HOLD, OVER} state_t;

    state_t             state_q, state_d;
    logic               run_q, run_d;
    logic               hit_q, hit_d;
    logic [HL_W-1:0]    hit_line_q, hit_line_d;
    logic               game_over_q, game_over_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CNT_W-1:0]   ovl_cnt_q, ovl_cnt_d;
    logic [HL_W-1:0]    hl_next_q, hl_next_d;
    logic [N_LINES-1:0] col_seen_q, col_seen_d;
    logic [N_LINES-1:0] prev_col_q, prev_col_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic               ovl;
    logic [HL_W-1:0]    hl_pix;
    logic               hl_found;
    logic [HL_W-1:0]    exits;
    logic [SCORE_W-1:0] score_sum;

    function automatic logic [HL_W-1:0] popcnt(input logic [N_LINES-1:0] v);
        logic [HL_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < N_LINES; i++) n = n + HL_W'(v[i]);
        return n;
    endfunction

`ifdef SCORE_BCD_EN
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99)         return s;
        else if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
        else                     return {s[7:4], s[3:0] + 4'd1};
    endfunction

    always_comb begin
        score_sum = score_q;
        for (int unsigned i = 0; i < N_LINES; i++)
            if (HL_W'(i) < exits) score_sum = bcd_inc(score_sum);
    end
`else
    logic [SCORE_W:0] score_wide;

    always_comb begin
        score_wide = {1'b0, score_q} + (SCORE_W + 1)'(exits);
        score_sum  = score_wide[SCORE_W] ? '1 : score_wide[SCORE_W-1:0];
    end
`endif

    assign ovl   = cube_px & ((|obstacle_px) | border_px);
    assign exits = popcnt(prev_col_q & ~col_seen_q);

    // Lowest-index obstacle wins; border-only overlap reports N_LINES.
    always_comb begin
        hl_pix   = HL_W'(N_LINES);
        hl_found = 1'b0;
        for (int unsigned i = 0; i < N_LINES; i++) begin
            if (!hl_found && obstacle_px[i]) begin
                hl_pix   = HL_W'(i);
                hl_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hit_d      = hit_q;
        hit_line_d = hit_line_q;
        score_d    = score_q;
        ovl_cnt_d  = ovl_cnt_q;
        hl_next_d  = hl_next_q;
        col_seen_d = col_seen_q;
        prev_col_d = prev_col_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            IDLE, OVER: begin
                // start outranks a coincident frame_tick; nothing is evaluated here.
                if (start) begin
                    state_d    = PLAY;
                    score_d    = '0;
                    hit_d      = 1'b0;
                    hit_line_d = '0;
                    ovl_cnt_d  = '0;
                    hl_next_d  = '0;
                    col_seen_d = '0;
                    prev_col_d = '0;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (ovl_cnt_q >= CNT_W'(HIT_THRESH)) begin
                        state_d    = HIT_HOLD;
                        hit_d      = 1'b1;
                        hit_line_d = hl_next_q;
                        hold_cnt_d = HOLD_W'(HOLD_FRAMES - 1);
                    end else begin
                        score_d = score_sum;
                    end
                    prev_col_d = col_seen_q;
                    col_seen_d = '0;
                    ovl_cnt_d  = '0;
                    hl_next_d  = '0;
                end else if (pix_valid) begin
                    if (ovl && ovl_cnt_q == '0) hl_next_d = hl_pix;
                    if (ovl && ovl_cnt_q < CNT_W'(HIT_THRESH)) ovl_cnt_d = ovl_cnt_q + 1'b1;
                    col_seen_d = col_seen_q | ({N_LINES{cube_px}} & col_px);
                end
            end
            HIT_HOLD: begin
                if (frame_tick) begin
                    if (hold_cnt_q == '0) state_d = OVER;
                    else hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) score_d = '0;

        run_d       = (state_d == PLAY);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            hit_q       <= 1'b0;
            hit_line_q  <= '0;
            game_over_q <= 1'b0;
            score_q     <= '0;
            ovl_cnt_q   <= '0;
            hl_next_q   <= '0;
            col_seen_q  <= '0;
            prev_col_q  <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            hit_q       <= hit_d;
            hit_line_q  <= hit_line_d;
            game_over_q <= game_over_d;
            score_q     <= score_d;
            ovl_cnt_q   <= ovl_cnt_d;
            hl_next_q   <= hl_next_d;
            col_seen_q  <= col_seen_d;
            prev_col_q  <= prev_col_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign run       = run_q;
    assign hit       = hit_q;
    assign hit_line  = hit_line_q;
    assign game_over = game_over_q;
    assign score     = score_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Directed self-checking bench for collision_monitor (HOLD_FRAMES overridden to 3 to keep the hold phase short).
module tb_collision_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_valid, frame_tick, cube_px, border_px, start, clear;
    logic [4:0] obstacle_px, col_px;
    logic       run, hit, game_over;
    logic [2:0] hit_line;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;
    logic [7:0] es;

    collision_monitor #(
        .N_LINES(5), .SCORE_W(8), .HIT_THRESH(4), .HOLD_FRAMES(3)
    ) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .frame_tick(frame_tick),
        .cube_px(cube_px), .obstacle_px(obstacle_px), .col_px(col_px), .border_px(border_px),
        .start(start), .clear(clear), .run(run), .hit(hit), .hit_line(hit_line),
        .game_over(game_over), .score(score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] exp_add(input logic [7:0] s, input int n);
        int d;
`ifdef SCORE_BCD_EN
        d = int'(s[7:4]) * 10 + int'(s[3:0]) + n;
        if (d > 99) d = 99;
        return 8'((d / 10) * 16 + (d % 10));
`else
        d = int'(s) + n;
        if (d > 255) d = 255;
        return 8'(d);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic c, input logic [4:0] o, input logic [4:0] cl, input logic b);
        pix_valid = 1'b1; cube_px = c; obstacle_px = o; col_px = cl; border_px = b;
        step();
        pix_valid = 1'b0; cube_px = 1'b0; obstacle_px = '0; col_px = '0; border_px = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; pix_valid = 0; frame_tick = 0; cube_px = 0; border_px = 0;
        start = 0; clear = 0; obstacle_px = '0; col_px = '0;
        repeat (2) step();
        check("rst_run", run, 0);
        check("rst_score", score, 0);
        reset = 1'b1;
        repeat (3) step();
        tick();
        check("idle_run", run, 0);
        check("idle_hit", hit, 0);
        check("idle_over", game_over, 0);
        check("idle_score", score, 0);

        pulse_start();
        check("start_run", run, 1);

        // 3 overlap pixels: below threshold
        repeat (3) px(1, 5'b00100, 5'b00100, 0);
        px(0, 5'b00100, 5'b00100, 0);
        tick();
        check("ovl3_hit", hit, 0);
        check("ovl3_run", run, 1);

        // 4 overlap pixels: hit on line 2
        repeat (4) px(1, 5'b00100, 5'b00100, 0);
        tick();
        check("ovl4_hit", hit, 1);
        check("ovl4_line", hit_line, 2);
        check("ovl4_run", run, 0);
        check("ovl4_over", game_over, 0);

        pulse_start();
        check("hold_start_ign", run, 0);
        tick();
        check("hold_t1", game_over, 0);
        tick();
        check("hold_t2", game_over, 0);
        tick();
        check("hold_t3", game_over, 1);
        check("over_hit", hit, 1);
        check("over_score", score, 0);

        // start coincident with frame_tick in OVER
        start = 1'b1; frame_tick = 1'b1;
        step();
        start = 1'b0; frame_tick = 1'b0;
        check("restart_run", run, 1);
        check("restart_hit", hit, 0);
        check("restart_line", hit_line, 0);
        check("restart_over", game_over, 0);
        tick();
        check("restart_prevcol", score, 0);

        // col0, col0, col1 -> one line cleared
        px(1, 5'b0, 5'b00001, 0); tick();
        px(1, 5'b0, 5'b00001, 0); tick();
        check("col_f2", score, 0);
        px(1, 5'b0, 5'b00010, 0); tick();
        es = exp_add(8'd0, 1);
        check("col_f3", score, es);
        px(1, 5'b0, 5'b00001, 0); px(1, 5'b0, 5'b01000, 0); px(1, 5'b0, 5'b00010, 0); tick();
        check("col_f4", score, es);
        px(1, 5'b0, 5'b00010, 0); tick();
        es = exp_add(es, 2);
        check("col_two_exit", score, es);

        // clear wins over a same-cycle increment (line 1 exits here)
        clear = 1'b1; tick(); clear = 1'b0;
        check("clear_vs_inc", score, 0);
        es = 8'd0;

        repeat (50) begin
            px(1, 5'b0, 5'b11111, 0); tick();
            tick();
            es = exp_add(es, 5);
        end
        check("sat_250", score, es);
        px(1, 5'b0, 5'b01111, 0); tick(); tick();
        es = exp_add(es, 4);
        check("sat_254", score, es);
        px(1, 5'b0, 5'b00011, 0); tick(); tick();
        es = exp_add(es, 2);
`ifdef SCORE_BCD_EN
        check("sat_max", score, 8'h99);
`else
        check("sat_max", score, 8'hFF);
`endif
        px(1, 5'b0, 5'b00011, 0); tick(); tick();
        check("sat_hold", score, es);

        // border-only overlap reports line N_LINES
        repeat (4) px(1, 5'b0, 5'b0, 1);
        tick();
        check("border_hit", hit, 1);
        check("border_line", hit_line, 5);
        check("border_score_frozen", score, es);

        // asynchronous reset mid-cycle
        pix_valid = 1'b1; cube_px = 1'b1; border_px = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("async_hit", hit, 0);
        check("async_line", hit_line, 0);
        check("async_score", score, 0);
        check("async_run", run, 0);
        pix_valid = 1'b0; cube_px = 1'b0; border_px = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("post_rst_over", game_over, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
